reg_file_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated pending-write scoreboard for the processor datapath's operand-preparation stage. The issue stage reserves destination registers. The writeback stage writes data and releases the reservation. Each read port reports whether its operand is valid. Register 0 is hardwired to zero.

---
 rtl/reg_file_sb.sv | 91 +++++++++
 tb/tb_reg_file_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a pending-write (busy-bit) scoreboard; r0 reads as zero.
// Optional write-through forwarding to the read ports when RF_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]   Read_register,
    output logic [NUM_RD*DATA_W-1:0]   Read_data,
    output logic [NUM_RD-1:0]          Read_ready,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          Write_register,
    input  logic [DATA_W-1:0]          Write_data,
    input  logic                       Issue_valid,
    input  logic [ADDR_W-1:0]          Issue_register,
    output logic                       Issue_accept,
    output logic [ADDR_W:0]            Pending_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  clear_mask;
    logic [DEPTH-1:0]  set_mask;
    logic              write_en;
    logic              release_hit;
    logic              issue_set;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];

    assign write_en    = RegWrite && (Write_register != '0);
    assign release_hit = write_en && busy[Write_register];

    // Issue handshake: Issue_accept is a same-cycle, combinational answer to
    // Issue_valid; there is no stall or hold, the source simply retries.
    // A write releasing the same register this cycle frees it for reissue.
    assign Issue_accept = Issue_valid &&
                          ((Issue_register == '0) || !busy[Issue_register] ||
                           (RegWrite && (Write_register == Issue_register)));
    assign issue_set    = Issue_accept && (Issue_register != '0);

    always_comb begin
        clear_mask = '0;
        set_mask   = '0;
        if (release_hit) clear_mask[Write_register] = 1'b1;
        if (issue_set)   set_mask[Issue_register]   = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy          <= '0;
            Pending_count <= '0;
        end else begin
            if (write_en) regs[Write_register] <= Write_data;
            // Clear before set, so a same-cycle release+reissue stays busy.
            busy <= (busy & ~clear_mask) | set_mask;
            if (issue_set && !release_hit)
                Pending_count <= Pending_count + ONE;
            else if (release_hit && !issue_set)
                Pending_count <= Pending_count - ONE;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
        assign rd_addr[k] = Read_register[k*ADDR_W +: ADDR_W];
    end

    always_comb begin
        Read_data  = '0;
        Read_ready = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            Read_data[k*DATA_W +: DATA_W] = regs[rd_addr[k]];
            Read_ready[k]                 = !busy[rd_addr[k]];
`ifdef RF_BYPASS_EN
            if (write_en && (Write_register == rd_addr[k])) begin
                Read_data[k*DATA_W +: DATA_W] = Write_data;
                Read_ready[k]                 = 1'b1;
            end
`endif
            if (rd_addr[k] == '0) begin
                Read_data[k*DATA_W +: DATA_W] = '0;
                Read_ready[k]                 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, write/read, scoreboard issue/release, bypass, count ceiling.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                     Clk = 1'b0;
    logic                     Reset_n;
    logic [NUM_RD*ADDR_W-1:0] Read_register;
    logic [NUM_RD*DATA_W-1:0] Read_data;
    logic [NUM_RD-1:0]        Read_ready;
    logic                     RegWrite;
    logic [ADDR_W-1:0]        Write_register;
    logic [DATA_W-1:0]        Write_data;
    logic                     Issue_valid;
    logic [ADDR_W-1:0]        Issue_register;
    logic                     Issue_accept;
    logic [ADDR_W:0]          Pending_count;

    logic [63:0]       exp_q [$];
    logic [DATA_W-1:0] model [DEPTH];
    int                total_cnt = 0;
    int                pass_cnt  = 0;
    int                fail_cnt  = 0;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Read_register  (Read_register),
        .Read_data      (Read_data),
        .Read_ready     (Read_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .Issue_valid    (Issue_valid),
        .Issue_register (Issue_register),
        .Issue_accept   (Issue_accept),
        .Pending_count  (Pending_count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_reads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        Read_register = {a1, a0};
    endtask

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        total_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h but no expected value queued", tag, obs);
            return;
        end
        exp_v = exp_q.pop_front();
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        RegWrite = 1'b1; Write_register = a; Write_data = d;
        tick();
        RegWrite = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    initial begin
        logic [ADDR_W-1:0] a0, a1;
        Reset_n = 1'b0; Read_register = '0; RegWrite = 1'b0; Write_register = '0;
        Write_data = '0; Issue_valid = 1'b0; Issue_register = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick(); tick();
        Reset_n = 1'b1;

        // Random writes and reservations, then a reset that also carries a write and issue.
        for (int i = 0; i < 6; i++)
            do_write(ADDR_W'($urandom_range(1, DEPTH-1)), $urandom);
        Issue_valid = 1'b1; Issue_register = 5'd12; tick();
        Issue_register = 5'd13; tick();
        Issue_valid = 1'b0;
        Reset_n = 1'b0; RegWrite = 1'b1; Write_register = 5'd20; Write_data = 32'hDEAD_BEEF;
        Issue_valid = 1'b1; Issue_register = 5'd21;
        tick();
        Reset_n = 1'b1; RegWrite = 1'b0; Issue_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < 4; i++) begin
            a0 = ADDR_W'($urandom_range(1, DEPTH-1));
            a1 = (i == 0) ? 5'd12 : (i == 1) ? 5'd20 : ADDR_W'($urandom_range(1, DEPTH-1));
            set_reads(a0, a1); #1;
            expect_val(64'd0);  check("reset_data", 64'(Read_data));
            expect_val(64'h3);  check("reset_ready", 64'(Read_ready));
        end
        expect_val(64'd0); check("reset_count", 64'(Pending_count));

        // Randomised write/read traffic against the model.
        for (int i = 0; i < 8; i++)
            do_write(ADDR_W'($urandom_range(1, DEPTH-1)), $urandom);
        for (int i = 0; i < 4; i++) begin
            a0 = ADDR_W'($urandom_range(0, DEPTH-1));
            a1 = ADDR_W'($urandom_range(0, DEPTH-1));
            set_reads(a0, a1); #1;
            expect_val({model[a1], model[a0]}); check("rand_read", 64'(Read_data));
        end

        // Directed write/read, and r0 stays zero.
        do_write(5'd25, 32'd15);
        do_write(5'd3, 32'd3);
        set_reads(5'd25, 5'd3); #1;
        expect_val({32'd3, 32'd15}); check("wr_rd_pair", 64'(Read_data));
        do_write(5'd0, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd0); #1;
        expect_val(64'd0); check("r0_zero", 64'(Read_data));
        expect_val(64'h3); check("r0_ready", 64'(Read_ready));

        // Issue r7, reissue refused, release by write.
        set_reads(5'd7, 5'd3);
        Issue_valid = 1'b1; Issue_register = 5'd7; #1;
        expect_val(64'd1); check("issue_r7_accept", 64'(Issue_accept));
        tick();
        Issue_valid = 1'b0; #1;
        expect_val(64'b10); check("r7_busy_ready", 64'(Read_ready));
        expect_val(64'd1);  check("r7_count", 64'(Pending_count));
        Issue_valid = 1'b1; #1;
        expect_val(64'd0); check("reissue_r7_refused", 64'(Issue_accept));
        Issue_valid = 1'b0;
        RegWrite = 1'b1; Write_register = 5'd7; Write_data = 32'h55; #1;
`ifdef RF_BYPASS_EN
        expect_val({model[3], 32'h55}); check("r7_wr_cycle_data", 64'(Read_data));
        expect_val(64'b11);             check("r7_wr_cycle_ready", 64'(Read_ready));
`else
        expect_val({model[3], model[7]}); check("r7_wr_cycle_data", 64'(Read_data));
        expect_val(64'b10);               check("r7_wr_cycle_ready", 64'(Read_ready));
`endif
        tick(); RegWrite = 1'b0; model[7] = 32'h55; #1;
        expect_val(64'b11);             check("r7_released_ready", 64'(Read_ready));
        expect_val({model[3], 32'h55}); check("r7_released_data", 64'(Read_data));
        expect_val(64'd0);              check("r7_released_count", 64'(Pending_count));

        // Same-cycle release and reissue of r9.
        Issue_valid = 1'b1; Issue_register = 5'd9; tick();
        RegWrite = 1'b1; Write_register = 5'd9; Write_data = 32'h99; #1;
        expect_val(64'd1); check("r9_release_issue_accept", 64'(Issue_accept));
        tick(); RegWrite = 1'b0; Issue_valid = 1'b0; model[9] = 32'h99;
        set_reads(5'd9, 5'd9); #1;
        expect_val(64'b00);                    check("r9_still_busy", 64'(Read_ready));
        expect_val(64'd1);                     check("r9_count_kept", 64'(Pending_count));
        expect_val({32'h99, 32'h99});          check("r9_data", 64'(Read_data));
        do_write(5'd9, 32'h9A); #1;
        expect_val(64'd0); check("r9_final_count", 64'(Pending_count));

        // Forwarding on port 1 while port 0 reads an unrelated register.
        do_write(5'd4, 32'h1111);
        Issue_valid = 1'b1; Issue_register = 5'd4; tick();
        Issue_valid = 1'b0;
        set_reads(5'd3, 5'd4);
        RegWrite = 1'b1; Write_register = 5'd4; Write_data = 32'hABCD; #1;
`ifdef RF_BYPASS_EN
        expect_val({32'hABCD, model[3]}); check("byp_data", 64'(Read_data));
        expect_val(64'b11);               check("byp_ready", 64'(Read_ready));
`else
        expect_val({32'h1111, model[3]}); check("byp_data", 64'(Read_data));
        expect_val(64'b01);               check("byp_ready", 64'(Read_ready));
`endif
        tick(); RegWrite = 1'b0; model[4] = 32'hABCD; #1;
        expect_val({32'hABCD, model[3]}); check("byp_after_data", 64'(Read_data));
        expect_val(64'b11);               check("byp_after_ready", 64'(Read_ready));

        // Reserve every nonzero register, then r0.
        for (int r = 1; r < DEPTH; r++) begin
            Issue_valid = 1'b1; Issue_register = ADDR_W'(r); #1;
            expect_val(64'd1); check("fill_accept", 64'(Issue_accept));
            tick();
        end
        Issue_valid = 1'b0; #1;
        expect_val(64'(DEPTH-1)); check("fill_count", 64'(Pending_count));
        Issue_valid = 1'b1; Issue_register = 5'd0; #1;
        expect_val(64'd1); check("issue_r0_accept", 64'(Issue_accept));
        tick();
        Issue_register = 5'd5; #1;
        expect_val(64'd0); check("full_r5_refused", 64'(Issue_accept));
        Issue_valid = 1'b0;
        set_reads(5'd0, 5'd17); #1;
        expect_val(64'(DEPTH-1)); check("ceiling_count", 64'(Pending_count));
        expect_val(64'b01);       check("full_ready", 64'(Read_ready));

        // Reset mid-operation drops all reservations.
        Reset_n = 1'b0; Issue_valid = 1'b1; Issue_register = 5'd0;
        RegWrite = 1'b1; Write_register = 5'd17; Write_data = 32'h1234;
        tick();
        Reset_n = 1'b1; Issue_valid = 1'b0; RegWrite = 1'b0; #1;
        expect_val(64'd0);  check("midreset_count", 64'(Pending_count));
        expect_val(64'b11); check("midreset_ready", 64'(Read_ready));
        expect_val(64'd0);  check("midreset_data", 64'(Read_data));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
